dircc_mixed_width_dpram: RTL and testbench
==========================================

# dircc_mixed_width_dpram

Parametrised mixed-width true dual-port on-chip memory for DiRCC processing nodes. It replaces the fixed 32/16-bit node processing memory with configurable width, ratio, depth and read latency. It adds an Avalon-style `waitrequest`/`readdatavalid` handshake, an optional post-reset zero-clear sequencer, and a defined same-cycle write-collision rule. Port A serves the Nios data master; port B serves the node's narrow fabric/mailbox side.

## Interface
- `BYTES_A`, 4: port A width in bytes; WA = 8*BYTES_A.
- `RATIO`, 2: port A / port B width ratio, legal values 1, 2, 4; WB = WA/RATIO, BYTES_B = BYTES_A/RATIO (must be ≥1).
- `DEPTH`, 10240: port A words; AW = clog2(DEPTH), BW = AW + clog2(RATIO).
- `READ_LATENCY`, 1: cycles from accepted read to `readdatavalid`, legal values 1 or 2.
- `CLEAR_ON_RESET`, 1: 1 means zero-fill the whole array after reset; 0 means contents are retained.
- `clk`  in  1  single clock for both ports.
- `reset`  in  1  synchronous, active-high.
- `reset_req`  in  1  freeze request: no new accesses accepted, pipeline held.
- `address_a`  in  AW  port A word address.
- `chipselect_a`, `read_a`, `write_a`  in  1 each  port A strobes.
- `byteenable_a`  in  BYTES_A  port A write lane mask.
- `writedata_a`  in  WA  port A write data.
- `readdata_a`  out  WA  port A read data.
- `readdatavalid_a`  out  1  port A read-data qualifier.
- `waitrequest_a`  out  1  port A stall.
- `address_b`, `chipselect_b`, `read_b`, `write_b`, `byteenable_b`, `writedata_b`, `readdata_b`, `readdatavalid_b`, `waitrequest_b`: same as port A with widths BW, 1, 1, 1, BYTES_B, WB, WB, 1, 1.
- `init_done`  out  1  high once the clear sequence has finished, or immediately after reset when CLEAR_ON_RESET=0.

## Operation
- Address mapping: B address b selects A word b[BW-1:clog2(RATIO)] and lane b[clog2(RATIO)-1:0]. Little-endian: lane 0 = A bits [WB-1:0]. Byte k of port B equals byte lane*BYTES_B+k of port A.
- Sequencer states are RESET, CLEAR and READY.
  - While `reset` is high: state RESET, clear counter 0, `init_done` 0, both `waitrequest` 1, `readdatavalid` 0, `readdata` 0, read pipeline flushed.
  - On the first cycle with `reset` low: go to CLEAR if CLEAR_ON_RESET=1, else go to READY.
  - CLEAR: writes zero to word `counter` each cycle (all lanes), then `counter++`. After word DEPTH-1 is written, go to READY next cycle. Total clear time is DEPTH cycles.
  - If `reset` is asserted mid-clear, the counter restarts at 0 and the sequence runs again from the start.
- READY: a port accepts an access when `chipselect & (read|write) & ~waitrequest`. `waitrequest` = ~READY | `reset_req`.
  - If `read` and `write` are both high on one port, the write executes and no read is issued.
- Writes update only the enabled byte lanes.
- Write collision: if both ports write the same byte in the same cycle, port A's byte is stored. Non-overlapping bytes of both writes are stored.
- Read-during-write: a read returns OLD_DATA, for both the same port and the mixed port.
- `reset_req` high: no new accepts. Reads already in flight complete and retain their latency. `readdata` holds its last value.

## Timing
- READ_LATENCY=1: a read accepted at edge n drives `readdata` and pulses `readdatavalid` for one cycle after edge n+1.
- READ_LATENCY=2: the output is registered and valid after edge n+2.
- Back-to-back reads are sustained at one per cycle per port. Valids arrive in issue order.
- A write takes effect at the accept edge. A read accepted on the following cycle returns the new data.
- `readdata` holds its last value while `readdatavalid` is 0.
- `init_done` rises on the same edge that enters READY, and `waitrequest` falls on that same edge.
- Reset values: `readdata_*` 0, `readdatavalid_*` 0, `waitrequest_*` 1, `init_done` 0.

## Test plan
- Clear test, parameters BYTES_A=4, RATIO=2, DEPTH=16. Preload word 5 = 0xDEADBEEF, reset, then wait → `init_done` rises exactly 16 cycles after reset deasserts. An A read of word 5 returns 0x00000000 with `readdatavalid` 1 cycle later.
- Mixed width: A writes word 3 = 0x11223344 → B read of address 6 returns 0x3344, and B read of address 7 returns 0x1122. B writes address 7 = 0xAABB with byteenable 2'b01 → A read of word 3 returns 0x11BB3344.
- Collision: same cycle, A writes word 2 = 0xFFFFFFFF with byteenable 4'b0011, and B writes address 4 = 0x1234 with byteenable 2'b11 → word 2 reads 0x0000FFFF, because port A wins both bytes of lane 0.
- Latency and throughput: READ_LATENCY=2, four back-to-back A reads of words 0-3 → four consecutive `readdatavalid` pulses starting 2 cycles after the first accept, with data in order.
- Freeze: assert `reset_req` one cycle after a read is accepted → that read's valid still arrives on time. `waitrequest` is 1 and no further accepts occur until `reset_req` drops.
- Reset mid-clear: assert reset at counter=9 for 1 cycle → `init_done` rises 16 cycles after reset deasserts, not 7.

Source files
------------

// File: rtl/dircc_mixed_width_dpram.sv
// dircc_mixed_width_dpram: mixed-width true dual-port node memory with
// Avalon-style handshake, post-reset zero-clear and port-A-wins collisions.
// Ports:
//   clk, reset (sync, active-high), reset_req (freeze new accepts)
//   port A: address_a[AW], chipselect_a, read_a, write_a,
//           byteenable_a[BYTES_A], writedata_a[WA] -> readdata_a[WA],
//           readdatavalid_a, waitrequest_a
//   port B: same handshake with BW address, WB data, BYTES_B lanes
//   init_done: array cleared (or retained) and ports open
module dircc_mixed_width_dpram #(
    parameter int BYTES_A        = 4,
    parameter int RATIO          = 2,
    parameter int DEPTH          = 10240,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int WA      = 8 * BYTES_A,
    localparam int WB      = WA / RATIO,
    localparam int BYTES_B = BYTES_A / RATIO,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = $clog2(RATIO),
    localparam int BW      = AW + LW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reset_req,
    input  logic [AW-1:0]      address_a,
    input  logic               chipselect_a,
    input  logic               read_a,
    input  logic               write_a,
    input  logic [BYTES_A-1:0] byteenable_a,
    input  logic [WA-1:0]      writedata_a,
    output logic [WA-1:0]      readdata_a,
    output logic               readdatavalid_a,
    output logic               waitrequest_a,
    input  logic [BW-1:0]      address_b,
    input  logic               chipselect_b,
    input  logic               read_b,
    input  logic               write_b,
    input  logic [BYTES_B-1:0] byteenable_b,
    input  logic [WB-1:0]      writedata_b,
    output logic [WB-1:0]      readdata_b,
    output logic               readdatavalid_b,
    output logic               waitrequest_b,
    output logic               init_done
);

    typedef enum logic [1:0] {
        S_RESET,
        S_CLEAR,
        S_READY
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            clr_we;
    logic            ready;
    logic            stall;

    logic [WA-1:0]   mem [DEPTH];

    logic [AW-1:0]   b_word;
    int              b_lane;

    logic            acc_a, acc_b;
    logic            wr_acc_a, wr_acc_b;
    logic            rd_acc_a, rd_acc_b;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            S_RESET: begin
                state_d = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            end
            S_CLEAR: begin
                clr_we = ~reset;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign ready     = (state_q == S_READY);
    assign init_done = ready;

    // reset is folded in so nothing is accepted on a reset edge
    assign stall         = ~ready | reset_req | reset;
    assign waitrequest_a = stall;
    assign waitrequest_b = stall;

    // ---------------- port decode ----------------
    assign b_word = address_b[BW-1:LW];

    if (LW > 0) begin : g_lane
        assign b_lane = int'(address_b[LW-1:0]);
    end else begin : g_nolane
        assign b_lane = 0;
    end

    assign acc_a    = chipselect_a & (read_a | write_a) & ~stall;
    assign acc_b    = chipselect_b & (read_b | write_b) & ~stall;
    // write wins when both strobes are set
    assign wr_acc_a = acc_a & write_a;
    assign wr_acc_b = acc_b & write_b;
    assign rd_acc_a = acc_a & ~write_a;
    assign rd_acc_b = acc_b & ~write_b;

    // ---------------- array writes ----------------
    // B lanes are applied first so that A's later assignment wins any
    // byte both ports touch in the same cycle.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr_acc_b) begin
                for (int k = 0; k < BYTES_B; k++) begin
                    if (byteenable_b[k]) begin
                        mem[b_word][(b_lane*BYTES_B + k)*8 +: 8]
                            <= writedata_b[k*8 +: 8];
                    end
                end
            end
            if (wr_acc_a) begin
                for (int k = 0; k < BYTES_A; k++) begin
                    if (byteenable_a[k]) begin
                        mem[address_a][k*8 +: 8] <= writedata_a[k*8 +: 8];
                    end
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    // Stage 0 samples the array at the accept edge, giving old data on
    // any same-cycle write.
    logic          rv0_a, rv0_b;
    logic [WA-1:0] rd0_a;
    logic [WB-1:0] rd0_b;
    logic          rvn_a, rvn_b;
    logic [WA-1:0] rdn_a;
    logic [WB-1:0] rdn_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            rv0_a <= 1'b0;
            rv0_b <= 1'b0;
        end else begin
            rv0_a <= rd_acc_a;
            rv0_b <= rd_acc_b;
        end
        if (rd_acc_a) begin
            rd0_a <= mem[address_a];
        end
        if (rd_acc_b) begin
            rd0_b <= mem[b_word][b_lane*WB +: WB];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic          rv1_a, rv1_b;
        logic [WA-1:0] rd1_a;
        logic [WB-1:0] rd1_b;

        always_ff @(posedge clk) begin
            if (reset) begin
                rv1_a <= 1'b0;
                rv1_b <= 1'b0;
            end else begin
                rv1_a <= rv0_a;
                rv1_b <= rv0_b;
            end
            if (rv0_a) begin
                rd1_a <= rd0_a;
            end
            if (rv0_b) begin
                rd1_b <= rd0_b;
            end
        end

        assign rvn_a = rv1_a;
        assign rvn_b = rv1_b;
        assign rdn_a = rd1_a;
        assign rdn_b = rd1_b;
    end else begin : g_lat1
        assign rvn_a = rv0_a;
        assign rvn_b = rv0_b;
        assign rdn_a = rd0_a;
        assign rdn_b = rd0_b;
    end

    // output registers hold the last word between valids
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_a      <= '0;
            readdata_b      <= '0;
            readdatavalid_a <= 1'b0;
            readdatavalid_b <= 1'b0;
        end else begin
            readdatavalid_a <= rvn_a;
            readdatavalid_b <= rvn_b;
            if (rvn_a) begin
                readdata_a <= rdn_a;
            end
            if (rvn_b) begin
                readdata_b <= rdn_b;
            end
        end
    end

endmodule

// File: tb/tb_dircc_mixed_width_dpram.sv
// tb_dircc_mixed_width_dpram: two instances (read latency 1 and 2) driven
// in lockstep and compared every cycle against a byte-array model.
module tb_dircc_mixed_width_dpram;

    localparam int DEPTH = 16;
    localparam int HN    = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reset_req;
    logic [3:0]  address_a;
    logic        cs_a, rd_a, wr_a;
    logic [3:0]  be_a;
    logic [31:0] wd_a;
    logic [4:0]  address_b;
    logic        cs_b, rd_b, wr_b;
    logic [1:0]  be_b;
    logic [15:0] wd_b;

    logic [31:0] rdata_a1, rdata_a2;
    logic [15:0] rdata_b1, rdata_b2;
    logic        rv_a1, rv_a2, rv_b1, rv_b2;
    logic        wq_a1, wq_a2, wq_b1, wq_b2;
    logic        done1, done2;

    dircc_mixed_width_dpram #(
        .BYTES_A(4), .RATIO(2), .DEPTH(DEPTH),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) u1 (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .address_a(address_a), .chipselect_a(cs_a),
        .read_a(rd_a), .write_a(wr_a),
        .byteenable_a(be_a), .writedata_a(wd_a),
        .readdata_a(rdata_a1), .readdatavalid_a(rv_a1),
        .waitrequest_a(wq_a1),
        .address_b(address_b), .chipselect_b(cs_b),
        .read_b(rd_b), .write_b(wr_b),
        .byteenable_b(be_b), .writedata_b(wd_b),
        .readdata_b(rdata_b1), .readdatavalid_b(rv_b1),
        .waitrequest_b(wq_b1),
        .init_done(done1)
    );

    dircc_mixed_width_dpram #(
        .BYTES_A(4), .RATIO(2), .DEPTH(DEPTH),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u2 (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .address_a(address_a), .chipselect_a(cs_a),
        .read_a(rd_a), .write_a(wr_a),
        .byteenable_a(be_a), .writedata_a(wd_a),
        .readdata_a(rdata_a2), .readdatavalid_a(rv_a2),
        .waitrequest_a(wq_a2),
        .address_b(address_b), .chipselect_b(cs_b),
        .read_b(rd_b), .write_b(wr_b),
        .byteenable_b(be_b), .writedata_b(wd_b),
        .readdata_b(rdata_b2), .readdatavalid_b(rv_b2),
        .waitrequest_b(wq_b2),
        .init_done(done2)
    );

    // ---------------- reference model ----------------
    logic [31:0] mref [DEPTH];
    int          phase   = 0;   // 0 reset, 1 clearing, 2 ready
    int          clr_cnt = 0;
    int          e       = 0;
    bit          hv_a [HN];
    bit          hv_b [HN];
    logic [31:0] hd_a [HN];
    logic [15:0] hd_b [HN];
    logic [31:0] ex_a [2];
    logic [15:0] ex_b [2];
    bit          ev_a [2];
    bit          ev_b [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     name, act, exp, e);
        end
    endtask

    task automatic step();
        int          idx, j, lb, wb;
        logic [31:0] w;
        bit          go, aa, ab;
        go = (phase == 2) && !reset_req && !reset;
        aa = go && cs_a && (rd_a || wr_a);
        ab = go && cs_b && (rd_b || wr_b);
        e++;
        idx = e % HN;
        hv_a[idx] = 1'b0;
        hv_b[idx] = 1'b0;
        wb = int'(address_b) / 2;
        lb = int'(address_b) % 2;
        if (reset) begin
            phase   = 0;
            clr_cnt = 0;
            for (int k = 0; k < 3; k++) begin
                hv_a[(e - k + HN) % HN] = 1'b0;
                hv_b[(e - k + HN) % HN] = 1'b0;
            end
            for (int l = 0; l < 2; l++) begin
                ex_a[l] = '0;
                ex_b[l] = '0;
            end
        end else begin
            if (aa && !wr_a) begin
                hv_a[idx] = 1'b1;
                hd_a[idx] = mref[address_a];
            end
            if (ab && !wr_b) begin
                w = mref[wb];
                hv_b[idx] = 1'b1;
                hd_b[idx] = w[lb*16 +: 16];
            end
            if (ab && wr_b) begin
                for (int k = 0; k < 2; k++) begin
                    if (be_b[k]) mref[wb][(lb*2 + k)*8 +: 8] = wd_b[k*8 +: 8];
                end
            end
            if (aa && wr_a) begin
                for (int k = 0; k < 4; k++) begin
                    if (be_a[k]) mref[address_a][k*8 +: 8] = wd_a[k*8 +: 8];
                end
            end
            if (phase == 0) begin
                phase   = 1;
                clr_cnt = 0;
            end else if (phase == 1) begin
                mref[clr_cnt] = '0;
                clr_cnt++;
                if (clr_cnt == DEPTH) phase = 2;
            end
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            j = (e - l - 1 + HN) % HN;
            ev_a[l] = hv_a[j];
            ev_b[l] = hv_b[j];
            if (hv_a[j]) ex_a[l] = hd_a[j];
            if (hv_b[j]) ex_b[l] = hd_b[j];
        end
        chk("wait_a", {wq_a1, wq_a2},
            {2{(phase != 2) || reset_req || reset}});
        chk("wait_b", {wq_b1, wq_b2},
            {2{(phase != 2) || reset_req || reset}});
        chk("init_done", {done1, done2}, {2{phase == 2}});
        chk("rv_a", {rv_a1, rv_a2}, {ev_a[0], ev_a[1]});
        chk("rv_b", {rv_b1, rv_b2}, {ev_b[0], ev_b[1]});
        chk("rd_a_L1", rdata_a1, ex_a[0]);
        chk("rd_a_L2", rdata_a2, ex_a[1]);
        chk("rd_b_L1", {16'h0, rdata_b1}, {16'h0, ex_b[0]});
        chk("rd_b_L2", {16'h0, rdata_b2}, {16'h0, ex_b[1]});
    endtask

    task automatic idle();
        cs_a = 0; rd_a = 0; wr_a = 0;
        cs_b = 0; rd_b = 0; wr_b = 0;
    endtask

    // single access on one port; for reads returns data and latency
    task automatic xact(input bit port, input bit w, input int addr,
                        input logic [3:0] be, input logic [31:0] d,
                        output logic [31:0] rdv, output int lat);
        int n;
        rdv = 'x;
        lat = 99;
        if (!port) begin
            cs_a = 1; rd_a = !w; wr_a = w;
            address_a = addr[3:0]; be_a = be; wd_a = d;
        end else begin
            cs_b = 1; rd_b = !w; wr_b = w;
            address_b = addr[4:0]; be_b = be[1:0]; wd_b = d[15:0];
        end
        n = 0;
        while ((port ? wq_b1 : wq_a1) && n < 50) begin
            step();
            n++;
        end
        if (n == 50) chk("xact_accept_timeout", 1, 0);
        step();
        idle();
        if (!w) begin
            for (int i = 1; i <= 10; i++) begin
                step();
                if (port ? rv_b1 : rv_a1) begin
                    rdv = port ? {16'h0, rdata_b1} : rdata_a1;
                    lat = i;
                    break;
                end
            end
        end
    endtask

    task automatic wait_init(input string name, input int expect_n);
        int n;
        n = 0;
        step();
        while (!done1 && n < 40) begin
            step();
            n++;
        end
        chk(name, n, expect_n);
    endtask

    typedef struct {
        bit          port;
        bit          w;
        int          addr;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [13];
    logic [31:0] rv;
    int          lat;

    initial begin
        tbl[0]  = '{0, 1, 3,  4'hF, 32'h11223344, 32'h0};
        tbl[1]  = '{1, 0, 6,  4'h0, 32'h0,        32'h3344};
        tbl[2]  = '{1, 0, 7,  4'h0, 32'h0,        32'h1122};
        tbl[3]  = '{1, 1, 7,  4'h1, 32'hAABB,     32'h0};
        tbl[4]  = '{0, 0, 3,  4'h0, 32'h0,        32'h11BB3344};
        tbl[5]  = '{0, 0, 5,  4'h0, 32'h0,        32'h0};
        tbl[6]  = '{1, 1, 0,  4'h2, 32'hCAFE,     32'h0};
        tbl[7]  = '{0, 0, 0,  4'h0, 32'h0,        32'h0000CA00};
        tbl[8]  = '{1, 1, 31, 4'h3, 32'h5566,     32'h0};
        tbl[9]  = '{0, 0, 15, 4'h0, 32'h0,        32'h55660000};
        tbl[10] = '{0, 1, 15, 4'h8, 32'h99999999, 32'h0};
        tbl[11] = '{1, 0, 31, 4'h0, 32'h0,        32'h9966};
        tbl[12] = '{1, 0, 30, 4'h0, 32'h0,        32'h0};

        reset = 1; reset_req = 0;
        address_a = '0; be_a = '0; wd_a = '0;
        address_b = '0; be_b = '0; wd_b = '0;
        idle();
        step();
        step();
        reset = 0;
        wait_init("init_first", 16);

        // clear test: preload, reset, clear length, word reads zero
        xact(0, 1, 5, 4'hF, 32'hDEADBEEF, rv, lat);
        xact(0, 0, 5, 4'h0, 32'h0, rv, lat);
        chk("preload", rv, 32'hDEADBEEF);
        reset = 1;
        step();
        reset = 0;
        wait_init("clr_time", 16);
        xact(0, 0, 5, 4'h0, 32'h0, rv, lat);
        chk("clr_word5", rv, 32'h0);
        chk("clr_lat", lat, 1);

        // mixed-width table
        for (int i = 0; i < 13; i++) begin
            xact(tbl[i].port, tbl[i].w, tbl[i].addr, tbl[i].be,
                 tbl[i].d, rv, lat);
            if (!tbl[i].w) begin
                chk($sformatf("tbl%0d_data", i), rv, tbl[i].exp);
                chk($sformatf("tbl%0d_lat", i), lat, 1);
            end
        end

        // collisions: A wins shared bytes, others merge
        cs_a = 1; wr_a = 1; address_a = 2; be_a = 4'b0011;
        wd_a = 32'hFFFFFFFF;
        cs_b = 1; wr_b = 1; address_b = 4; be_b = 2'b11; wd_b = 16'h1234;
        step();
        idle();
        xact(0, 0, 2, 4'h0, 32'h0, rv, lat);
        chk("coll_full", rv, 32'h0000FFFF);
        cs_a = 1; wr_a = 1; address_a = 6; be_a = 4'b0010;
        wd_a = 32'hAAAAAAAA;
        cs_b = 1; wr_b = 1; address_b = 12; be_b = 2'b11; wd_b = 16'h1234;
        step();
        idle();
        xact(0, 0, 6, 4'h0, 32'h0, rv, lat);
        chk("coll_part", rv, 32'h0000AA34);

        // back-to-back reads
        for (int i = 0; i < 4; i++) begin
            xact(0, 1, i, 4'hF, 32'hA0000000 + i, rv, lat);
        end
        cs_a = 1; rd_a = 1; wr_a = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) address_a = 4'(k);
            else idle();
            step();
            chk("tp_v2", rv_a2, (k >= 2 && k <= 5));
            chk("tp_v1", rv_a1, (k >= 1 && k <= 4));
            if (k >= 2 && k <= 5) chk("tp_d2", rdata_a2, 32'hA0000000 + k - 2);
            if (k >= 1 && k <= 4) chk("tp_d1", rdata_a1, 32'hA0000000 + k - 1);
        end

        // freeze one cycle after an accepted read
        cs_a = 1; rd_a = 1; address_a = 3;
        step();
        reset_req = 1;
        address_a = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("frz_wait", wq_a1, 1);
            chk("frz_v1", rv_a1, (k == 1));
            chk("frz_v2", rv_a2, (k == 2));
            chk("frz_hold", rdata_a1, 32'hA0000003);
        end
        reset_req = 0;
        step();
        idle();
        step();
        chk("frz_resume_v", rv_a1, 1);
        chk("frz_resume_d", rdata_a1, 32'hA0000001);

        // reset in the middle of the clear sequence (counter = 9)
        reset = 1;
        step();
        reset = 0;
        step();
        for (int k = 0; k < 9; k++) step();
        chk("mid_not_done", done1, 0);
        reset = 1;
        step();
        reset = 0;
        wait_init("mid_clr_time", 16);
        xact(0, 0, 2, 4'h0, 32'h0, rv, lat);
        chk("mid_word2", rv, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            reset_req = ($urandom_range(0, 9) == 0);
            cs_a = 1'($urandom_range(0, 1));
            rd_a = 1'($urandom_range(0, 1));
            wr_a = 1'($urandom_range(0, 1));
            address_a = 4'($urandom_range(0, 15));
            be_a = 4'($urandom);
            wd_a = $urandom;
            cs_b = 1'($urandom_range(0, 1));
            rd_b = 1'($urandom_range(0, 1));
            wr_b = 1'($urandom_range(0, 1));
            address_b = 5'($urandom_range(0, 31));
            be_b = 2'($urandom);
            wd_b = 16'($urandom);
            step();
        end
        idle();
        reset_req = 0;
        for (int i = 0; i < 4; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
